// File: rtl/uart_pkt_sched_pkg.sv
// Shared definitions for the UART packet scheduler: state encoding and
// default header / timeout values.
package uart_pkt_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_GUARD = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [7:0] HDR0_DEF    = 8'hA5;
  localparam logic [7:0] HDR1_DEF    = 8'h5A;
  // 10 bits at 2605 clk/bit plus margin
  localparam int         TIMEOUT_DEF = 30000;

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin arbiter. The last-grant pointer advances only when
// upd is high and a grant is actually issued.
module uart_rr_arb
  import uart_pkt_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic gnt0,
  output logic gnt1
);

  // last = 1 means requester 1 was granted most recently
  logic last;

  always_comb begin
    gnt0 = req0 & (~req1 | last);
    gnt1 = req1 & (~req0 | ~last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (upd && (gnt0 || gnt1)) begin
      last <= gnt1;
    end
  end

endmodule

// File: rtl/uart_pkt_sched.sv
// Serialises 4-byte packets (header + 24-bit payload) from two requesters
// onto a byte UART, with round-robin arbitration and a per-byte timeout.
module uart_pkt_sched
  import uart_pkt_sched_pkg::*;
#(
  parameter int         TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] pay0,
  input  logic [23:0] pay1,
  output logic        ack0,
  output logic        ack1,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        pkt_done,
  output logic        err
);

  localparam int               CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      pkt;
  logic             gnt0;
  logic             gnt1;
  logic             upd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) return v;
    return v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] p, input logic [1:0] i);
    case (i)
      2'd0:    return p[31:24];
      2'd1:    return p[23:16];
      2'd2:    return p[15:8];
      default: return p[7:0];
    endcase
  endfunction

  assign upd     = (state == ST_IDLE);
  assign busy    = (state != ST_IDLE);
  assign cnt_inc = sat_inc(cnt);

  uart_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .upd   (upd),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  // Packet shift image is pure data; it is only meaningful after a grant.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && (gnt0 || gnt1)) begin
      pkt <= gnt1 ? {HDR1, pay1} : {HDR0, pay0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= 2'd0;
      cnt      <= '0;
      trmt     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      pkt_done <= 1'b0;
      err      <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      trmt     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      pkt_done <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            ack0  <= gnt0;
            ack1  <= gnt1;
            idx   <= 2'd0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          trmt    <= 1'b1;
          tx_data <= pick_byte(pkt, idx);
          state   <= ST_GUARD;
        end
        // UART is still clearing tx_done from the previous frame here
        ST_GUARD: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (idx == 2'd3) begin
              pkt_done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= ST_LOAD;
            end
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= TO_LIM) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_pkt_sched.md
UART_PKT_SCHED -- requirements
Module: uart_pkt_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 30000: max clk cycles to wait for tx_done per byte (10 bits at 2605 clk/bit plus margin).
REQ-002 Parameter HDR0, default 8'hA5: header byte for requester 0 packets.
REQ-003 Parameter HDR1, default 8'h5A: header byte for requester 1 packets.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req0, req1  input  1 each  level request to send one packet; held until matching ack.
REQ-007 pay0, pay1  input  24 each  payload for each requester; sampled only at grant.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: payload captured, request consumed.
REQ-009 trmt  output  1  one-cycle pulse starting one UART byte.
REQ-010 tx_data  output  8  byte presented to the UART; stable from trmt until next byte load.
REQ-011 tx_done  input  1  UART completion level; cleared by UART one cycle after trmt, set at end of frame.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 pkt_done  output  1  one-cycle pulse after the last byte of a packet completes.
REQ-014 err  output  1  one-cycle pulse on per-byte timeout.

Function
REQ-015 Packet = 4 bytes in order: header (HDR0/HDR1 by grantee), pay[23:16], pay[15:8], pay[7:0].
REQ-016 States: IDLE, LOAD, GUARD, WAIT, DONE.
REQ-017 IDLE: any req high -> register grant, latch header+payload, byte index 0, pulse ack of grantee in the next cycle, go LOAD.
REQ-018 Only one ack per grant; ack and grant never go to a requester that was low in the deciding cycle.
REQ-019 Arbitration round-robin: both requesting -> grant the one not granted last; last-grant pointer resets to 1, so requester 0 wins first.
REQ-020 LOAD: trmt=1 for exactly one cycle, tx_data = byte[index]; -> GUARD.
REQ-021 GUARD: one cycle; tx_done ignored (UART still clearing it); timeout counter cleared; -> WAIT.
REQ-022 WAIT: tx_done=1 -> index==3 ? DONE : (index+1, LOAD); else increment timeout counter.
REQ-023 WAIT: counter reaching TIMEOUT_CYC with tx_done=0 -> err pulse, abandon packet, -> IDLE; no pkt_done.
REQ-024 DONE: pkt_done=1 one cycle; -> IDLE; new request can be granted from the next IDLE cycle.
REQ-025 Requests arriving while busy are not sampled; held requests are served after return to IDLE.
REQ-026 Byte index 2 bits, no wrap beyond 3; timeout counter wide enough for TIMEOUT_CYC, saturates, never wraps.
REQ-027 trmt, ack0, ack1, pkt_done, err never high in the same cycle as each other, except none.

Reset
REQ-028 rst_n low, any state: state=IDLE, trmt=0, ack0=ack1=0, pkt_done=0, err=0, busy=0, tx_data=8'h00, index=0, counter=0, last-grant pointer=1.
REQ-029 Reset mid-packet abandons the packet silently; no err or pkt_done pulse is produced on release.

Structure
REQ-030 Shared package holds state encoding typedef, default HDR0/HDR1, default TIMEOUT_CYC.
REQ-031 One sub-module: uart_rr_arb (2-way round-robin arbiter with last-grant pointer and update enable); remaining logic in uart_pkt_sched.

Verification
REQ-032 req0=1, pay0=24'h123456, UART model -> ack0 one cycle; trmt 4 times with tx_data A5,12,34,56; pkt_done once after the 4th tx_done.
REQ-033 req0 and req1 high same cycle (pay1=24'hABCDEF) -> packet A5,... first, then 5A,AB,CD,EF; exactly one ack each.
REQ-034 req0 and req1 held for 4 packets -> grants alternate 0,1,0,1.
REQ-035 tx_done stuck 0 after first trmt -> err pulse at TIMEOUT_CYC cycles into WAIT, busy drops, no further trmt, no pkt_done.
REQ-036 rst_n low during WAIT of byte 2 -> all outputs at reset values immediately; after release with no req, trmt stays 0.
REQ-037 tx_done already high when trmt fires -> GUARD ignores it; next trmt only after UART sets tx_done again (≥10 bit times).
